vrased_reset_seq: RTL

Reset sequencer for the VRASED hardware monitor. Takes the six per-monitor violation flags (X_stack, AC, atomicity, dma_AC, dma_detect, dma_X_stack), drives the PUC request with a zero-latency assert, and holds it for a programmable number of cycles. It then waits for the CPU to fetch from the reset handler before re-arming. It also captures the violation cause and keeps a saturating violation count for post-reset attestation diagnostics.

---
 rtl/vrased_pkg.sv | 27 ++
 rtl/vrased_cause_enc.sv | 26 ++
 rtl/vrased_reset_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/vrased_pkg.sv
// Purpose : shared constants for the VRASED reset sequencer (monitor count, cause indices, FSM encoding).
// Latency : n/a (package only).
// Backpress: n/a (package only).
//
// Contents: NUM_MON, CAUSE_* indices into the viol vector, NO_CAUSE marker, state_t encoding.
package vrased_pkg;

    localparam int NUM_MON = 6;

    // Bit positions of each monitor flag inside viol.
    localparam logic [2:0] CAUSE_XSTACK     = 3'd0;
    localparam logic [2:0] CAUSE_AC         = 3'd1;
    localparam logic [2:0] CAUSE_ATOMIC     = 3'd2;
    localparam logic [2:0] CAUSE_DMA_AC     = 3'd3;
    localparam logic [2:0] CAUSE_DMA_DETECT = 3'd4;
    localparam logic [2:0] CAUSE_DMA_XSTACK = 3'd5;

    // Reported when no violation has been logged since the last clear.
    localparam logic [2:0] NO_CAUSE = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        WAIT_PC = 2'd2
    } state_t;

endpackage

// File: rtl/vrased_cause_enc.sv
// Purpose : 6-to-3 lowest-index priority encoder for the violation flags.
// Latency : combinational, 0 cycles.
// Backpress: none; pure function of the input.
//
// Ports: vec (monitor flags in), idx (lowest set index out, NO_CAUSE when vec is zero).
// Only built together with the cause log (macro VRASED_RST_LOG_EN); without the log nothing uses it.
`ifdef VRASED_RST_LOG_EN
module vrased_cause_enc
    import vrased_pkg::*;
(
    input  logic [NUM_MON-1:0] vec,
    output logic [2:0]         idx
);

    always_comb begin
        idx = NO_CAUSE;
        if      (vec[CAUSE_XSTACK])     idx = CAUSE_XSTACK;
        else if (vec[CAUSE_AC])         idx = CAUSE_AC;
        else if (vec[CAUSE_ATOMIC])     idx = CAUSE_ATOMIC;
        else if (vec[CAUSE_DMA_AC])     idx = CAUSE_DMA_AC;
        else if (vec[CAUSE_DMA_DETECT]) idx = CAUSE_DMA_DETECT;
        else if (vec[CAUSE_DMA_XSTACK]) idx = CAUSE_DMA_XSTACK;
    end

endmodule
`endif

// File: rtl/vrased_reset_seq.sv
// Purpose : VRASED reset sequencer; asserts PUC on any monitor violation, holds it, waits for the CPU restart fetch.
// Latency : reset follows viol combinationally (0 cycles); busy and the cause log are registered (valid next cycle).
// Backpress: none; violations are never stalled, every cycle with a violation drives reset.
//
// Ports: clk, reset_n (async active-low), viol[5:0], pc[15:0], cause_clr -> reset, busy, cause_vec, first_cause, viol_cnt.
// Macro VRASED_RST_LOG_EN: when defined, builds the cause log (cause_vec, first_cause, viol_cnt);
// when undefined those outputs are tied to 0 / NO_CAUSE / 0 and cause_clr has no effect.
module vrased_reset_seq
    import vrased_pkg::*;
#(
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int unsigned HOLD_CYCLES   = 4          // legal 1..255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_MON-1:0] viol,
    input  logic [15:0]        pc,
    input  logic               cause_clr,
    output logic               reset,
    output logic               busy,
    output logic [NUM_MON-1:0] cause_vec,
    output logic [2:0]         first_cause,
    output logic [7:0]         viol_cnt
);

    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

    state_t     state;
    logic [7:0] hold_cnt;
    logic       any_viol;

    assign any_viol = |viol;

    // Must stay combinational: the violating cycle itself has to see reset.
    assign reset = any_viol | (state == HOLD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_viol) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_RELOAD;
                        busy     <= 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == 8'd0) begin
                        // A violation on the last hold cycle extends the same episode.
                        if (any_viol) begin
                            hold_cnt <= HOLD_RELOAD;
                        end else begin
                            state <= WAIT_PC;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                WAIT_PC: begin
                    // A fresh violation outranks the restart fetch.
                    if (any_viol) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_RELOAD;
                    end else if (pc == RESET_HANDLER) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef VRASED_RST_LOG_EN
    logic [2:0] viol_idx;
    logic       new_episode;
    logic       clr_idle;

    vrased_cause_enc u_cause_enc (
        .vec (viol),
        .idx (viol_idx)
    );

    // Violations in HOLD belong to the running episode; IDLE and WAIT_PC start a new one.
    assign new_episode = any_viol && ((state == IDLE) || (state == WAIT_PC));
    assign clr_idle    = cause_clr && (state == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_vec   <= '0;
            first_cause <= NO_CAUSE;
            viol_cnt    <= '0;
        end else begin
            if (clr_idle) begin
                // Clear and concurrent violation: the violation becomes the new log.
                cause_vec   <= viol;
                first_cause <= viol_idx;
            end else if (any_viol) begin
                cause_vec <= cause_vec | viol;
                if (new_episode && (cause_vec == '0)) begin
                    first_cause <= viol_idx;
                end
            end

            if (new_episode && (viol_cnt != 8'hFF)) begin
                viol_cnt <= viol_cnt + 8'd1;
            end
        end
    end
`else
    logic unused_cause_clr;
    assign unused_cause_clr = cause_clr;

    assign cause_vec   = '0;
    assign first_cause = NO_CAUSE;
    assign viol_cnt    = '0;
`endif

endmodule
